// File: rtl/param_loader_if.sv
// Bundles the command, the load stream, the engine write port and the result signals.
// The slave modport is the loader's view of the bundle and the master modport is the driver's view.
interface param_loader_if;
  logic               go;
  logic               load_all;
  logic signed [15:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic [15:0]        ld_wdata;
  logic [12:0]        ld_waddr;
  logic               we;
  logic               we_b12;
  logic               w23_we;
  logic               b23_we;
  logic               we_data;
  logic               start;
  logic [9:0]         onehot_enc;
  logic [3:0]         result_idx;
  logic               result_valid;
  logic               result_err;
  logic               busy;

  modport slave (
    input  go, load_all, in_data, in_valid, onehot_enc,
    output in_ready, ld_wdata, ld_waddr, we, we_b12, w23_we, b23_we, we_data,
           start, result_idx, result_valid, result_err, busy
  );

  modport master (
    output go, load_all, in_data, in_valid, onehot_enc,
    input  in_ready, ld_wdata, ld_waddr, we, we_b12, w23_we, b23_we, we_data,
           start, result_idx, result_valid, result_err, busy
  );
endinterface

// File: rtl/param_loader.sv
// Streams weights, biases and an image into the inference engine memories, pulses start, then reports the decoded result.
// Defining PARAM_LOADER_ONEHOT_CHECK_EN adds a check that the engine output is a valid one-hot code.
module param_loader #(
  parameter int W12_DEPTH    = 5120,
  parameter int B12_DEPTH    = 20,
  parameter int W23_DEPTH    = 200,
  parameter int B23_DEPTH    = 10,
  parameter int IMG_DEPTH    = 256,
  parameter int START_LEN    = 5,
  parameter int INFER_CYCLES = 5400
) (
  input  logic           clk,
  input  logic           reset,
  param_loader_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE, LD_W12, LD_B12, LD_W23, LD_B23, LD_IMG, START, WAIT, REPORT
  } state_t;

  state_t      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [31:0] tmr_q, tmr_d;
  logic [4:0]  en_q, en_d;
  logic [15:0] wdata_q, wdata_d;
  logic [12:0] waddr_q, waddr_d;
  logic [3:0]  ridx_q, ridx_d;
  logic        rerr_q, rerr_d;

  logic        is_ld;
  logic        accept;
  logic [12:0] last_idx;
  logic [4:0]  region_sel;
  state_t      next_region;
  logic [3:0]  low_idx;
  logic [3:0]  dec_idx;
  logic        dec_err;

  // Per-region last index, enable select and successor region.
  always_comb begin
    is_ld       = 1'b1;
    last_idx    = '0;
    region_sel  = '0;
    next_region = IDLE;
    case (state_q)
      LD_W12: begin last_idx = 13'(W12_DEPTH - 1); region_sel = 5'b00001; next_region = LD_B12; end
      LD_B12: begin last_idx = 13'(B12_DEPTH - 1); region_sel = 5'b00010; next_region = LD_W23; end
      LD_W23: begin last_idx = 13'(W23_DEPTH - 1); region_sel = 5'b00100; next_region = LD_B23; end
      LD_B23: begin last_idx = 13'(B23_DEPTH - 1); region_sel = 5'b01000; next_region = LD_IMG; end
      LD_IMG: begin last_idx = 13'(IMG_DEPTH - 1); region_sel = 5'b10000; next_region = START;  end
      default: is_ld = 1'b0;
    endcase
  end

  assign accept = is_ld && bus.in_valid;

  // Downward scan so the lowest set bit wins; no bit set yields 0.
  always_comb begin
    low_idx = '0;
    for (int i = 9; i >= 0; i--) begin
      if (bus.onehot_enc[i]) low_idx = 4'(i);
    end
  end

`ifdef PARAM_LOADER_ONEHOT_CHECK_EN
  assign dec_err = ($countones(bus.onehot_enc) != 1);
  assign dec_idx = dec_err ? 4'd15 : low_idx;
`else
  assign dec_err = 1'b0;
  assign dec_idx = low_idx;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    en_d    = '0;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    ridx_d  = ridx_q;
    rerr_d  = rerr_q;
    case (state_q)
      IDLE: begin
        if (bus.go) begin
          state_d = bus.load_all ? LD_W12 : LD_IMG;
          cnt_d   = '0;
        end
      end
      LD_W12, LD_B12, LD_W23, LD_B23, LD_IMG: begin
        if (accept) begin
          en_d    = region_sel;
          waddr_d = cnt_q;
          wdata_d = (state_q == LD_IMG) ? {14'd0, bus.in_data[1:0]} : bus.in_data;
          if (cnt_q == last_idx) begin
            cnt_d   = '0;
            state_d = next_region;
          end else begin
            cnt_d = cnt_q + 13'd1;
          end
        end
      end
      START: begin
        if (tmr_q == 32'(START_LEN - 1)) begin
          tmr_d   = '0;
          state_d = WAIT;
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end
      WAIT: begin
        if (tmr_q == 32'(INFER_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = REPORT;
        end else begin
          tmr_d = tmr_q + 32'd1;
        end
      end
      REPORT: begin
        ridx_d  = dec_idx;
        rerr_d  = dec_err;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tmr_q   <= '0;
      en_q    <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
      ridx_q  <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      en_q    <= en_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      ridx_q  <= ridx_d;
      rerr_q  <= rerr_d;
    end
  end

  assign bus.in_ready     = is_ld;
  assign bus.ld_wdata     = wdata_q;
  assign bus.ld_waddr     = waddr_q;
  assign bus.we           = en_q[0];
  assign bus.we_b12       = en_q[1];
  assign bus.w23_we       = en_q[2];
  assign bus.b23_we       = en_q[3];
  assign bus.we_data      = en_q[4];
  assign bus.start        = (state_q == START);
  assign bus.busy         = (state_q != IDLE);
  assign bus.result_valid = (state_q == REPORT);
  // During REPORT the live decode is shown; afterwards the captured copy holds.
  assign bus.result_idx   = (state_q == REPORT) ? dec_idx : ridx_q;
  assign bus.result_err   = (state_q == REPORT) ? dec_err : rerr_q;

endmodule

// File: doc/param_loader.md
PARAM_LOADER -- requirements
Module: param_loader

Interface
REQ-001 The block SHALL have parameter W12_DEPTH, default 5120, giving the number of layer-1 weight words loaded.
REQ-002 The block SHALL have parameter B12_DEPTH, default 20, giving the number of layer-1 bias words.
REQ-003 The block SHALL have parameter W23_DEPTH, default 200, giving the number of layer-2 weight words.
REQ-004 The block SHALL have parameter B23_DEPTH, default 10, giving the number of layer-2 bias words.
REQ-005 The block SHALL have parameter IMG_DEPTH, default 256, giving the number of 2-bit pixel words.
REQ-006 The block SHALL have parameter START_LEN, default 5, giving the start pulse width in cycles.
REQ-007 The block SHALL have parameter INFER_CYCLES, default 5400, giving the cycles waited after start before sampling the engine result.
REQ-008 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- go  in  1  one-cycle command pulse.
- load_all  in  1  sampled with go; 1 = load all regions, 0 = image only.
- in_data  in  16  stream word, signed.
- in_valid  in  1  stream word valid.
- in_ready  out  1  stream word accepted when in_valid and in_ready are both 1.
- ld_wdata  out  16  write data to engine memories.
- ld_waddr  out  13  write address, zero-extended per region.
- we, we_b12, w23_we, b23_we, we_data  out  1 each  per-region write enables.
- start  out  1  engine start.
- onehot_enc  in  10  engine classification.
- result_idx  out  4  decoded digit.
- result_valid  out  1  one-cycle pulse.
- result_err  out  1  invalid one-hot flag.
- busy  out  1  high whenever the state is not IDLE.

Function
REQ-009 The state machine SHALL have states IDLE, LD_W12, LD_B12, LD_W23, LD_B23, LD_IMG, START, WAIT and REPORT.
REQ-010 In IDLE, go=1 SHALL move to LD_W12 if load_all=1, else to LD_IMG; go outside IDLE SHALL be ignored.
REQ-011 in_ready SHALL be 1 only in LD_* states.
REQ-012 Each accepted word SHALL produce exactly one write with latency 1: on the next cycle the region's enable is 1 for one cycle, ld_waddr holds the word index and ld_wdata holds in_data.
REQ-013 In LD_IMG, ld_wdata[1:0] SHALL carry in_data[1:0] and ld_wdata[15:2] SHALL be 0.
REQ-014 The region counter SHALL start at 0, advance on each accept, and on accepting index DEPTH-1 SHALL clear to 0 and move to the next region: W12 -> B12 -> W23 -> B23 -> IMG -> START.
REQ-015 in_valid stalls of any length SHALL insert no writes and lose no words.
REQ-016 All enables SHALL be 0 in cycles with no accept.
REQ-017 START SHALL drive start=1 for exactly START_LEN cycles and then enter WAIT.
REQ-018 WAIT SHALL count INFER_CYCLES cycles and then enter REPORT.
REQ-019 REPORT SHALL last one cycle: result_valid=1, result_idx = index of the lowest set bit of onehot_enc (0 if none), followed by return to IDLE.
REQ-020 result_idx and result_err SHALL hold their values until the next REPORT.

Reset
REQ-021 reset=0 SHALL asynchronously force IDLE, clear all counters, and drive every output to 0, including result_idx, result_err and busy.
REQ-022 Reset asserted mid-load or mid-WAIT SHALL abort the operation with no further writes or start; a new go is required after reset is released.

Configuration
REQ-023 With macro PARAM_LOADER_ONEHOT_CHECK_EN defined, REPORT SHALL set result_err=1 and result_idx=15 when the popcount of onehot_enc is not 1; otherwise result_err=0.
REQ-024 Without PARAM_LOADER_ONEHOT_CHECK_EN, result_err SHALL be tied to 0 and the check logic SHALL be absent.

Verification
REQ-025 Full load, go with load_all=1, in_valid held at 1 -> writes land on each region's enable at indices 0..DEPTH-1 (W12 5120 writes; B12 20; W23 200; B23 10; IMG 256), then start=1 for 5 cycles.
REQ-026 Image-only load, go with load_all=0 -> only we_data pulses (256 times), then start.
REQ-027 in_valid toggled every other cycle in LD_B12 -> exactly 20 we_b12 pulses at addresses 0..19 in order.
REQ-028 onehot_enc=10'b0000100000 at REPORT -> result_idx=5, result_valid=1 for one cycle; with the macro, onehot_enc=10'b0000000011 -> result_err=1, result_idx=15.
REQ-029 Reset pulsed low at W12 index 100 -> all outputs 0 immediately; after release, go restarts at LD_W12 with address 0.
REQ-030 go asserted during WAIT -> ignored, and exactly one result_valid pulse occurs per accepted go.
